trig_cfg_seq: RTL and testbench

Trigger configuration sequencer between the host command decoder and the trigger-condition table. It accepts one decoded command per strobe and applies it to the trigger resources: single-slot table writes, whole-table sweeps, trigger enable, trigger-delay load and soft re-arm. Decoded commands arrive as (order, data) pairs. While a sweep is running, the sequencer is the sole writer of the table and drops new host commands.

---
 rtl/trig_cfg_pkg.sv | 18 +
 rtl/trig_sweep_ctr.sv | 41 ++++
 rtl/trig_cfg_seq.sv | 168 ++++++++++++++++
 tb/tb_trig_cfg_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/trig_cfg_pkg.sv
// Shared opcode constants and sequencer state encoding for the trigger
// configuration sequencer.
package trig_cfg_pkg;

  localparam logic [3:0] OP_CLRALL  = 4'hF;
  localparam logic [3:0] OP_SETSLOT = 4'hE;
  localparam logic [3:0] OP_INIT    = 4'hD;
  localparam logic [3:0] OP_EN      = 4'hC;
  localparam logic [3:0] OP_DIS     = 4'hB;
  localparam logic [3:0] OP_TIME    = 4'hA;
  localparam logic [3:0] OP_RELOAD  = 4'h9;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/trig_sweep_ctr.sv
// Sweep address counter: start clears it to 0, step advances it and it
// saturates on the terminal address so it never wraps while sweeping.
module trig_sweep_ctr #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] cnt_nxt,
  output logic              last
);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  assign last    = (cnt_q == {ADDR_W{1'b1}});
  assign cnt_nxt = cnt_d;

  // next address: restart, advance or hold at the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = {ADDR_W{1'b0}};
    end else if (step && !last) begin
      cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt_q <= {ADDR_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trig_cfg_seq.sv
// Trigger configuration sequencer: decodes host commands into trigger table
// writes, full-table sweeps, enable, delay load and re-arm pulses.
module trig_cfg_seq
  import trig_cfg_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int CMD_W  = 4,
  parameter int TIME_W = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_order,
  input  logic [7:0]        cmd_data,
  output logic              cmd_ready,
  output logic              cmd_drop,
  output logic              tw_en,
  output logic [ADDR_W-1:0] tw_addr,
  output logic [CMD_W-1:0]  tw_data,
  output logic              trig_en,
  output logic [TIME_W-1:0] trig_time,
  output logic              time_valid,
  output logic              arm,
  output logic              busy
);

  state_e             state_q, state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               cmd_drop_q, cmd_drop_d;
  logic               tw_en_q, tw_en_d;
  logic [ADDR_W-1:0]  tw_addr_q, tw_addr_d;
  logic [CMD_W-1:0]   tw_data_q, tw_data_d;
  logic               trig_en_q, trig_en_d;
  logic [TIME_W-1:0]  trig_time_q, trig_time_d;
  logic [7:0]         shadow_q, shadow_d;
  logic               time_valid_q, time_valid_d;
  logic               arm_q, arm_d;
  logic               busy_q, busy_d;

  logic               ctr_start_s;
  logic               ctr_step_s;
  logic [ADDR_W-1:0]  ctr_nxt_s;
  logic               ctr_last_s;

  trig_sweep_ctr #(
    .ADDR_W (ADDR_W)
  ) u_sweep_ctr (
    .clk     (CLK),
    .clr_n   (CLR),
    .start   (ctr_start_s),
    .step    (ctr_step_s),
    .cnt_nxt (ctr_nxt_s),
    .last    (ctr_last_s)
  );

  // command decode, sweep sequencing and next values of every output register
  always_comb begin
    state_d      = state_q;
    cmd_drop_d   = 1'b0;
    tw_en_d      = 1'b0;
    tw_addr_d    = tw_addr_q;
    tw_data_d    = tw_data_q;
    trig_en_d    = trig_en_q;
    trig_time_d  = trig_time_q;
    shadow_d     = shadow_q;
    time_valid_d = 1'b0;
    arm_d        = 1'b0;
    ctr_start_s  = 1'b0;
    ctr_step_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_order[7:4])
            OP_CLRALL, OP_INIT: begin
              state_d     = SWEEP;
              ctr_start_s = 1'b1;
              tw_en_d     = 1'b1;
              tw_addr_d   = ctr_nxt_s;
              // tw_data doubles as the latched fill value for the whole sweep
              if (cmd_order[7:4] == OP_INIT) begin
                tw_data_d = cmd_data[CMD_W-1:0];
              end else begin
                tw_data_d = {CMD_W{1'b0}};
              end
            end
            OP_SETSLOT: begin
              tw_en_d   = 1'b1;
              tw_addr_d = cmd_order[ADDR_W-1:0];
              tw_data_d = cmd_data[CMD_W-1:0];
            end
            OP_EN:  trig_en_d = 1'b1;
            OP_DIS: trig_en_d = 1'b0;
            OP_TIME: begin
              if (cmd_order[0]) begin
                trig_time_d  = TIME_W'({cmd_data, shadow_q});
                time_valid_d = 1'b1;
              end else begin
                shadow_d = cmd_data;
              end
            end
            OP_RELOAD: arm_d = 1'b1;
            default: ;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      SWEEP: begin
        ctr_step_s = 1'b1;
        cmd_drop_d = cmd_valid;
        if (ctr_last_s) begin
          state_d = IDLE;
        end else begin
          tw_en_d   = 1'b1;
          tw_addr_d = ctr_nxt_s;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == SWEEP);
    cmd_ready_d = (state_d == IDLE);
  end

  // output and state registers
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      cmd_drop_q   <= 1'b0;
      tw_en_q      <= 1'b0;
      tw_addr_q    <= {ADDR_W{1'b0}};
      tw_data_q    <= {CMD_W{1'b0}};
      trig_en_q    <= 1'b1;
      trig_time_q  <= {TIME_W{1'b0}};
      shadow_q     <= 8'h00;
      time_valid_q <= 1'b0;
      arm_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      cmd_drop_q   <= cmd_drop_d;
      tw_en_q      <= tw_en_d;
      tw_addr_q    <= tw_addr_d;
      tw_data_q    <= tw_data_d;
      trig_en_q    <= trig_en_d;
      trig_time_q  <= trig_time_d;
      shadow_q     <= shadow_d;
      time_valid_q <= time_valid_d;
      arm_q        <= arm_d;
      busy_q       <= busy_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign cmd_drop   = cmd_drop_q;
  assign tw_en      = tw_en_q;
  assign tw_addr    = tw_addr_q;
  assign tw_data    = tw_data_q;
  assign trig_en    = trig_en_q;
  assign trig_time  = trig_time_q;
  assign time_valid = time_valid_q;
  assign arm        = arm_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_trig_cfg_seq.sv
// Directed bench for trig_cfg_seq: stimulus pushes expected pulse events
// into a cycle-ordered queue that a negedge monitor pops and compares.
module tb_trig_cfg_seq;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_order = 8'h00;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_ready, cmd_drop, tw_en, trig_en, time_valid, arm, busy;
  logic [3:0]  tw_addr, tw_data;
  logic [15:0] trig_time;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    bit          we;
    logic [3:0]  a;
    logic [3:0]  d;
    bit          tv;
    logic [15:0] t;
    bit          arm;
    bit          drop;
  } ev_t;

  ev_t exp_q[$];

  trig_cfg_seq dut (
    .CLK(CLK), .CLR(CLR), .cmd_valid(cmd_valid), .cmd_order(cmd_order),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .cmd_drop(cmd_drop),
    .tw_en(tw_en), .tw_addr(tw_addr), .tw_data(tw_data), .trig_en(trig_en),
    .trig_time(trig_time), .time_valid(time_valid), .arm(arm), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // events landing on the same cycle are merged into one record
  function automatic void add_ev(ev_t e);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc == e.cyc) begin
        ev_t m = exp_q[i];
        if (e.we) begin m.we = 1'b1; m.a = e.a; m.d = e.d; end
        if (e.tv) begin m.tv = 1'b1; m.t = e.t; end
        if (e.arm) m.arm = 1'b1;
        if (e.drop) m.drop = 1'b1;
        exp_q[i] = m;
        return;
      end
      if (exp_q[i].cyc > e.cyc) begin
        exp_q.insert(i, e);
        return;
      end
    end
    exp_q.push_back(e);
  endfunction

  function automatic ev_t blank(int c);
    ev_t e;
    e.cyc = c; e.we = 1'b0; e.a = 4'h0; e.d = 4'h0;
    e.tv = 1'b0; e.t = 16'h0000; e.arm = 1'b0; e.drop = 1'b0;
    return e;
  endfunction

  function automatic void exp_wr(int c, logic [3:0] a, logic [3:0] d);
    ev_t e = blank(c);
    e.we = 1'b1; e.a = a; e.d = d;
    add_ev(e);
  endfunction

  function automatic void exp_tv(int c, logic [15:0] t);
    ev_t e = blank(c);
    e.tv = 1'b1; e.t = t;
    add_ev(e);
  endfunction

  function automatic void exp_arm(int c);
    ev_t e = blank(c);
    e.arm = 1'b1;
    add_ev(e);
  endfunction

  function automatic void exp_drop(int c);
    ev_t e = blank(c);
    e.drop = 1'b1;
    add_ev(e);
  endfunction

  // monitor: every pulse cycle must match the head of the expectation queue
  always @(negedge CLK) begin
    bit any;
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL missing_event cyc=%0d actual=none required=expected_cyc_%0d", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    any = (tw_en === 1'b1) || (time_valid === 1'b1) || (arm === 1'b1) || (cmd_drop === 1'b1);
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (tw_en !== e.we || (e.we && (tw_addr !== e.a || tw_data !== e.d)) ||
          time_valid !== e.tv || (e.tv && trig_time !== e.t) ||
          arm !== e.arm || cmd_drop !== e.drop) begin
        errors++;
        $display("FAIL event cyc=%0d actual we=%b a=%h d=%h tv=%b t=%h arm=%b drop=%b required we=%b a=%h d=%h tv=%b t=%h arm=%b drop=%b",
                 cyc, tw_en, tw_addr, tw_data, time_valid, trig_time, arm, cmd_drop,
                 e.we, e.a, e.d, e.tv, e.t, e.arm, e.drop);
      end
    end else if (any) begin
      checks++; errors++;
      $display("FAIL unexpected_event cyc=%0d actual we=%b a=%h d=%h tv=%b arm=%b drop=%b required=no_pulse",
               cyc, tw_en, tw_addr, tw_data, time_valid, arm, cmd_drop);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // drive one command for exactly one cycle; leaves cmd_valid high for chaining
  task automatic send(input logic [7:0] o, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_order = o; cmd_data = d;
    @(negedge CLK); #1;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) begin @(negedge CLK); #1; end
  endtask

  int c;

  initial begin
    // reset
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    CLR = 1'b1;
    chk("rst_trig_en", {31'd0, trig_en}, 32'd1);
    chk("rst_trig_time", {16'd0, trig_time}, 32'h0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tw_en", {31'd0, tw_en}, 32'd0);

    // single slot write, then address/data hold
    c = cyc; exp_wr(c + 1, 4'h5, 4'hA);
    send(8'hE5, 8'h0A);
    idle(2);
    chk("hold_tw_addr", {28'd0, tw_addr}, 32'h5);
    chk("hold_tw_data", {28'd0, tw_data}, 32'hA);
    chk("slot_ready", {31'd0, cmd_ready}, 32'd1);

    // highest slot with data upper nibble ignored
    c = cyc; exp_wr(c + 1, 4'hF, 4'h7);
    send(8'hEF, 8'hC7);
    send(8'hB0, 8'h00);
    idle(1);
    chk("dis_trig_en", {31'd0, trig_en}, 32'd0);

    // init sweep with a dropped enable in the middle
    c = cyc;
    for (int k = 0; k < 16; k++) exp_wr(c + 1 + k, k[3:0], 4'h3);
    send(8'hD0, 8'h03);
    chk("sweep_busy", {31'd0, busy}, 32'd1);
    chk("sweep_ready", {31'd0, cmd_ready}, 32'd0);
    idle(3);
    exp_drop(cyc + 1);
    send(8'hC0, 8'h00);
    idle(11);
    chk("sweep_last_busy", {31'd0, busy}, 32'd1);
    chk("sweep_trig_en", {31'd0, trig_en}, 32'd0);
    idle(1);
    chk("sweep_end_ready", {31'd0, cmd_ready}, 32'd1);
    chk("sweep_end_busy", {31'd0, busy}, 32'd0);
    send(8'hC0, 8'h00);
    chk("en_after_sweep", {31'd0, trig_en}, 32'd1);

    // two-byte delay load, back to back
    send(8'hA0, 8'h34);
    c = cyc; exp_tv(c + 1, 16'h1234);
    send(8'hA1, 8'h12);
    idle(1);
    chk("trig_time", {16'd0, trig_time}, 32'h1234);

    // disable, re-arm, ignored opcode
    send(8'hB0, 8'h00);
    c = cyc; exp_arm(c + 1);
    send(8'h90, 8'h00);
    send(8'h50, 8'hFF);
    idle(3);
    chk("dis_en", {31'd0, trig_en}, 32'd0);
    chk("ign_time", {16'd0, trig_time}, 32'h1234);
    chk("ign_ready", {31'd0, cmd_ready}, 32'd1);

    // clear-all sweep aborted by reset
    c = cyc;
    for (int k = 0; k < 7; k++) exp_wr(c + 1 + k, k[3:0], 4'h0);
    send(8'hF0, 8'hFF);
    idle(6);
    CLR = 1'b0;
    idle(1);
    CLR = 1'b1;
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_trig_en", {31'd0, trig_en}, 32'd1);
    chk("abort_trig_time", {16'd0, trig_time}, 32'h0);
    idle(20);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
